// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU that takes the operand pair from the operand-select logic.
// It accepts one RV32I operation per valid/ready handshake. Arithmetic and
// logic operations finish in one cycle. Shifts run iteratively, one bit
// position per cycle. The result and destination register are held until
// writeback takes them.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RESET      synchronous, active-high reset
//   IN_VALID   operation presented on DATA0/DATA1/OPCODE/FUNCT3/FUNCT7_5/RD
//   IN_READY   unit can accept an operation (high only while idle)
//   DATA0      operand 0
//   DATA1      operand 1 (DATA1[SHAMT_W-1:0] is the shift amount)
//   OPCODE     RV32I opcode
//   FUNCT3     RV32I funct3
//   FUNCT7_5   instr[30], selects SUB / SRA
//   RD         destination register, passed through to RD_OUT
//   OUT_VALID  RESULT / RD_OUT / ILLEGAL are valid
//   OUT_READY  writeback accepts the result
//   RESULT     computed result (holds its last value after the handshake)
//   RD_OUT     registered destination register
//   ILLEGAL    opcode was outside the supported set
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic             FUNCT7_5,
  input  logic [4:0]       RD,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic [4:0]       RD_OUT,
  output logic             ILLEGAL
);

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_shift(input logic [6:0] op, input logic [2:0] f3);
    op_is_shift = ((op == OP_REG) || (op == OP_IMM)) &&
                  ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  // Single-cycle result. Shift encodings only reach this function with a
  // zero shift amount, so they return operand 0 unchanged.
  function automatic logic [WIDTH-1:0] alu_compute(
    input logic [6:0]       op,
    input logic [2:0]       f3,
    input logic             f7,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      OP_REG, OP_IMM: begin
        case (f3)
          3'b000:         res = (op == OP_REG && f7) ? a - b : a + b;
          3'b010:         res = {{(WIDTH-1){1'b0}}, (sa < sb)};
          3'b011:         res = {{(WIDTH-1){1'b0}}, (a < b)};
          3'b100:         res = a ^ b;
          3'b110:         res = a | b;
          3'b111:         res = a & b;
          default:        res = a;
        endcase
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC: res = a + b;
      default:                             res = '0;
    endcase
    alu_compute = res;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [1:0]       kind,
    input logic [WIDTH-1:0] w
  );
    case (kind)
      SH_LL:   shift_step = {w[WIDTH-2:0], 1'b0};
      SH_RL:   shift_step = {1'b0, w[WIDTH-1:1]};
      default: shift_step = {w[WIDTH-1], w[WIDTH-1:1]};
    endcase
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] count_q;
  logic [1:0]         kind_q;
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         rd_q;
  logic               illegal_q;

  logic [SHAMT_W-1:0] shamt_in;
  logic               start_shift;
  logic [1:0]         kind_in;
  logic [WIDTH-1:0]   shift_next;
  logic               last_shift;

  assign shamt_in    = DATA1[SHAMT_W-1:0];
  assign start_shift = op_is_shift(OPCODE, FUNCT3) && (shamt_in != '0);
  assign kind_in     = (FUNCT3 == 3'b001) ? SH_LL : (FUNCT7_5 ? SH_RA : SH_RL);
  assign shift_next  = shift_step(kind_q, work_q);
  assign last_shift  = (count_q == SHAMT_W'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_d = start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (last_shift) state_d = S_DONE;
      end
      S_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- accept / iterate stage: operands latched, result registered ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      work_q    <= '0;
      count_q   <= '0;
      kind_q    <= SH_LL;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID) begin
            rd_q <= RD;
            if (start_shift) begin
              work_q    <= DATA0;
              count_q   <= shamt_in;
              kind_q    <= kind_in;
              illegal_q <= 1'b0;
            end else begin
              result_q  <= alu_compute(OPCODE, FUNCT3, FUNCT7_5, DATA0, DATA1);
              illegal_q <= ~op_legal(OPCODE);
            end
          end
        end
        S_SHIFT: begin
          // The final step lands directly in the result register.
          if (last_shift) begin
            result_q <= shift_next;
          end else begin
            work_q  <= shift_next;
            count_q <= count_q - SHAMT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign RESULT  = result_q;
  assign RD_OUT  = rd_q;
  assign ILLEGAL = illegal_q;

endmodule
